// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the shift_tx serial transmitter: FSM state
// encodings, default frame geometry and a counter-width helper.
package led_ctrl_pkg;

  // FSM states. ST_LATCH is only reachable when SHIFT_TX_LATCH_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Default frame width in bits and clk cycles per serial bit.
  localparam int DEFAULT_MSB     = 8;
  localparam int DEFAULT_CLK_DIV = 4;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int count_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_tx_sclk_gen.sv
// Serial clock generator for shift_tx: owns the per-bit divider count,
// produces the registered sclk level (low first half, high second half of
// each bit window) and the bit-end tick on the last cycle of a window.
import led_ctrl_pkg::*;

module sclk_gen #(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic sclk_en,
  output logic sclk,
  output logic tick
);

  localparam int CW = count_width(CLK_DIV);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLK_DIV / 2);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          sclk_reg;
  logic          sclk_next;
  logic          last_cnt;

  // Next divider count and next sclk level; sclk is computed from the count
  // the window will hold next cycle so the output comes straight from a flop.
  always_comb begin
    last_cnt  = (cnt_reg == LAST_CNT);
    cnt_next  = '0;
    sclk_next = 1'b0;
    if (run && !last_cnt) begin
      cnt_next = cnt_reg + 1'b1;
    end
    // A window end always returns sclk low; the following window starts low.
    if (sclk_en && run && !last_cnt) begin
      sclk_next = (cnt_next >= HALF_CNT);
    end
  end

  // Divider count and sclk register; reset drops sclk at once so no
  // partial pulse can follow a reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg  <= '0;
      sclk_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      sclk_reg <= sclk_next;
    end
  end

  assign sclk = sclk_reg;
  assign tick = run && last_cnt;

endmodule

// File: rtl/shift_tx.sv
// shift_tx: parallel-to-serial transmitter for a downstream shift register.
// Captures din on start, sends it MSB first with sclk/sen_n framing, then
// pulses done. Optional macro SHIFT_TX_LATCH_EN adds a CLK_DIV-cycle latch
// strobe phase between the last bit and done; without it latch is tied low.
import led_ctrl_pkg::*;

module shift_tx #(
  parameter int MSB     = DEFAULT_MSB,
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [MSB-1:0] din,
  output logic           busy,
  output logic           done,
  output logic           sclk,
  output logic           sdata,
  output logic           sen_n,
  output logic           latch
);

  localparam int BW = count_width(MSB + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(MSB - 1);

  state_t         state_reg;
  // Holds the bits not yet on the line; the bit being sent sits in sdata_reg.
  logic [MSB-2:0] shift_buf_reg;
  logic [BW-1:0]  bit_cnt_reg;
  logic           busy_reg;
  logic           done_reg;
  logic           sdata_reg;
  logic           sen_n_reg;
  logic           run;
  logic           sclk_en;
  logic           tick;
`ifdef SHIFT_TX_LATCH_EN
  logic           latch_reg;
`endif

  // The divider runs through every bit window and, if present, the latch phase.
  always_comb begin
    sclk_en = (state_reg == ST_SHIFT);
`ifdef SHIFT_TX_LATCH_EN
    run     = (state_reg == ST_SHIFT) || (state_reg == ST_LATCH);
`else
    run     = (state_reg == ST_SHIFT);
`endif
  end

  sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .sclk_en (sclk_en),
    .sclk    (sclk),
    .tick    (tick)
  );

  // Frame FSM with bit counter, shift buffer and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      shift_buf_reg <= '0;
      bit_cnt_reg   <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      sdata_reg     <= 1'b0;
      sen_n_reg     <= 1'b1;
`ifdef SHIFT_TX_LATCH_EN
      latch_reg     <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            sdata_reg     <= din[MSB-1];
            shift_buf_reg <= din[MSB-2:0];
            bit_cnt_reg   <= '0;
            sen_n_reg     <= 1'b0;
            busy_reg      <= 1'b1;
            state_reg     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (bit_cnt_reg == LAST_BIT) begin
              sdata_reg   <= 1'b0;
              sen_n_reg   <= 1'b1;
              bit_cnt_reg <= '0;
`ifdef SHIFT_TX_LATCH_EN
              latch_reg   <= 1'b1;
              state_reg   <= ST_LATCH;
`else
              done_reg    <= 1'b1;
              state_reg   <= ST_DONE;
`endif
            end else begin
              bit_cnt_reg   <= bit_cnt_reg + 1'b1;
              sdata_reg     <= shift_buf_reg[MSB-2];
              shift_buf_reg <= shift_buf_reg << 1;
            end
          end
        end
`ifdef SHIFT_TX_LATCH_EN
        ST_LATCH: begin
          if (tick) begin
            latch_reg <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          sdata_reg <= 1'b0;
          sen_n_reg <= 1'b1;
`ifdef SHIFT_TX_LATCH_EN
          latch_reg <= 1'b0;
`endif
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_reg;
  assign done  = done_reg;
  assign sdata = sdata_reg;
  assign sen_n = sen_n_reg;
`ifdef SHIFT_TX_LATCH_EN
  assign latch = latch_reg;
`else
  assign latch = 1'b0;
`endif

endmodule

// File: tb/tb_shift_tx.sv
// Scoreboard bench for shift_tx: two instances (MSB=8/CLK_DIV=4 and
// MSB=2/CLK_DIV=2) share start/din/reset. A per-instance model decides
// which starts are accepted and queues the frames; a separate monitor pops
// a frame when busy rises and checks every cycle against the frame timing
// rules, plus the word assembled by a modelled downstream shift register.
`timescale 1ns/1ps

module tb_shift_tx;

`ifdef SHIFT_TX_LATCH_EN
  localparam int LAT_EN = 1;
`else
  localparam int LAT_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] din = 8'h00;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  logic       drain_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] word;
    int         acc;
  } frame_t;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Expected {busy,done,sclk,sdata,sen_n,latch} at cycle t after acceptance.
  function automatic logic [5:0] expect_at(input int msb, input int d,
                                           input logic [7:0] word, input int t);
    int shift_end = msb * d;
    int done_t    = shift_end + LAT_EN * d + 1;
    logic b, dn, sc, sd, sn, la;
    b  = (t >= 1) && (t <= done_t);
    dn = (t == done_t);
    la = (t > shift_end) && (t <= shift_end + LAT_EN * d);
    if (t >= 1 && t <= shift_end) begin
      sc = (((t - 1) % d) >= d / 2);
      sd = word[msb - 1 - (t - 1) / d];
      sn = 1'b0;
    end else begin
      sc = 1'b0;
      sd = 1'b0;
      sn = 1'b1;
    end
    return {b, dn, sc, sd, sn, la};
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int P_MSB  = (gi == 0) ? 8 : 2;
    localparam int P_DIV  = (gi == 0) ? 4 : 2;
    localparam int DONE_T = P_MSB * P_DIV + LAT_EN * P_DIV + 1;
    localparam logic [7:0] MASK = 8'((1 << P_MSB) - 1);

    logic busy, done, sclk, sdata, sen_n, latch;
    frame_t q[$];
    frame_t cur;
    int     free_cyc = 0;
    bit     in_frame = 1'b0;
    int     t = 0;
    int     rises = 0;
    logic [7:0] rx = 8'h00;
    logic   prev_sclk = 1'b0;
    logic [5:0] act;

    shift_tx #(
      .MSB     (P_MSB),
      .CLK_DIV (P_DIV)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .din   (din[P_MSB-1:0]),
      .busy  (busy),
      .done  (done),
      .sclk  (sclk),
      .sdata (sdata),
      .sen_n (sen_n),
      .latch (latch)
    );

    assign act = {busy, done, sclk, sdata, sen_n, latch};

    // Model: a start is taken only once the previous frame has fully ended.
    always @(negedge clk) begin
      if (!reset) begin
        q.delete();
        free_cyc = 0;
      end else if (start && cyc >= free_cyc) begin
        q.push_back('{word: din & MASK, acc: cyc});
        free_cyc = cyc + DONE_T + 1;
      end
    end

    // Monitor: pops a frame when busy rises and checks every cycle.
    always @(negedge clk) begin
      if (!reset) begin
        in_frame = 1'b0;
        chk(act == 6'b000010, $sformatf("reset_state[%0d]", gi), act, 6'b000010);
      end else begin
        if (!in_frame && busy) begin
          if (q.size() == 0) begin
            chk(1'b0, $sformatf("spurious_frame[%0d] cyc=%0d", gi, cyc), 1, 0);
          end else begin
            cur = q.pop_front();
            in_frame = 1'b1;
            rises = 0;
            rx = 8'h00;
            prev_sclk = 1'b0;
            chk(cyc - cur.acc == 1, $sformatf("accept_latency[%0d]", gi), cyc - cur.acc, 1);
          end
        end
        if (in_frame) begin
          t = cyc - cur.acc;
          chk(act == expect_at(P_MSB, P_DIV, cur.word, t),
              $sformatf("outputs[%0d] t=%0d word=%0h", gi, t, cur.word),
              act, expect_at(P_MSB, P_DIV, cur.word, t));
          if (sclk && !prev_sclk) begin
            rises++;
            rx = {rx[6:0], sdata};
          end
          prev_sclk = sclk;
          if (t >= DONE_T) begin
            chk((rx & MASK) == cur.word, $sformatf("frame_word[%0d]", gi), rx & MASK, cur.word);
            chk(rises == P_MSB, $sformatf("sclk_rises[%0d]", gi), rises, P_MSB);
            in_frame = 1'b0;
          end
        end else if (!busy) begin
          chk(act == 6'b000010, $sformatf("idle_outputs[%0d] cyc=%0d", gi, cyc), act, 6'b000010);
        end
      end
    end

    // Asynchronous reset must reach the outputs within the same cycle.
    always @(negedge reset) begin
      #1;
      chk(act == 6'b000010, $sformatf("async_reset[%0d]", gi), act, 6'b000010);
    end

    always @(posedge drain_done) begin
      chk(q.size() == 0 && !in_frame, $sformatf("drained[%0d]", gi), q.size(), 0);
    end
  end

  task automatic drive(input logic s, input logic [7:0] d);
    @(posedge clk);
    #2;
    start = s;
    din   = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    idle(3);
    // Single frame A5 (second instance sees 2'b01).
    drive(1'b1, 8'hA5);
    idle(40);
    // Second instance sees 2'b10.
    drive(1'b1, 8'h82);
    idle(40);
    // Start pulses with din=FF while the 01 frame is in flight.
    drive(1'b1, 8'h01);
    for (int i = 0; i < 20; i++) drive(1'($urandom_range(0, 1)), 8'hFF);
    idle(40);
    // Start held high: back-to-back frames.
    for (int i = 0; i < 110; i++) drive(1'b1, 8'h3C);
    idle(40);
    // Reset at cycle 10 of a frame, then an 81 frame.
    drive(1'b1, 8'h5A);
    idle(9);
    @(posedge clk);
    #2;
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    drive(1'b1, 8'h81);
    idle(40);
    // Randomized traffic.
    for (int i = 0; i < 600; i++) drive(1'($urandom_range(0, 3) == 0), 8'($urandom));
    idle(60);
    drain_done = 1'b1;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Time limit guard.
  initial begin
    #200000;
    $display("FAIL timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
